video_timing_sequencer: RTL and testbench

Generates composite-video line/frame timing for the OSD datapath at 16 MHz and sequences the 5-bit DAC level. Each cycle it drives one of three sources: sync, black, or a pixel fetched from the overlay pixel source over a fixed-latency request/response handshake. It sits between the pixel-generating logic and the DAC output pins in the top level, replacing ad-hoc level muxing.

---
 rtl/video_timing_sequencer.sv | 127 ++++++++++++
 tb/tb_video_timing_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_sequencer.sv
// Composite-video line/frame timing generator and 5-bit DAC level sequencer.
// Stage 0 counts h/v, stage 1 classifies and requests pixels, stage 2 drives the DAC code.
module video_timing_sequencer #(
  parameter int LINE_CYCLES       = 1024,
  parameter int HSYNC_CYCLES      = 75,
  parameter int ACTIVE_START      = 192,
  parameter int ACTIVE_LEN        = 768,
  parameter int FRAME_LINES       = 312,
  parameter int VSYNC_LINES       = 3,
  parameter int ACTIVE_LINE_START = 23,
  parameter int ACTIVE_LINES      = 256,
  parameter int BLACK_LEVEL       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       pixel_req,
  output logic [9:0] x,
  output logic [8:0] y,
  input  logic [4:0] pixel_level,
  input  logic       pixel_valid,
  output logic [4:0] video,
  output logic       valid,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] underruns
);

  localparam int H_W = $clog2(LINE_CYCLES);
  localparam int V_W = $clog2(FRAME_LINES);
  localparam logic [H_W-1:0] H_LAST = H_W'(LINE_CYCLES - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(FRAME_LINES - 1);

  // BLACK encodes as zero so cleared and idle stage-1 registers both mean "black".
  typedef enum logic [1:0] {
    REG_BLACK  = 2'd0,
    REG_SYNC   = 2'd1,
    REG_ACTIVE = 2'd2
  } region_t;

  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  region_t        region0;
  region_t        region1;
  logic           line_start1;
  logic           frame_start1;

  // Stage 0: free-running raster counters, parked at (0,0) while disabled.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else if (!enable) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_comb begin
    // NOTE: assigning a default before any branch keeps this purely combinational (no latch).
    region0 = REG_BLACK;
    if (int'(v) < VSYNC_LINES) begin
      if (int'(h) < LINE_CYCLES - HSYNC_CYCLES) region0 = REG_SYNC;
    end else if (int'(h) < HSYNC_CYCLES) begin
      region0 = REG_SYNC;
    end else if (int'(v) >= ACTIVE_LINE_START &&
                 int'(v) <  ACTIVE_LINE_START + ACTIVE_LINES &&
                 int'(h) >= ACTIVE_START &&
                 int'(h) <  ACTIVE_START + ACTIVE_LEN) begin
      region0 = REG_ACTIVE;
    end
  end

  // Stage 1: registered region plus the pixel request coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      region1      <= REG_BLACK;
      x            <= '0;
      y            <= '0;
      line_start1  <= 1'b0;
      frame_start1 <= 1'b0;
    end else if (!enable) begin
      region1      <= REG_BLACK;
      x            <= '0;
      y            <= '0;
      line_start1  <= 1'b0;
      frame_start1 <= 1'b0;
    end else begin
      region1      <= region0;
      x            <= (region0 == REG_ACTIVE) ? 10'(int'(h) - ACTIVE_START) : '0;
      y            <= (region0 == REG_ACTIVE) ? 9'(int'(v) - ACTIVE_LINE_START) : '0;
      line_start1  <= (h == '0);
      frame_start1 <= (h == '0) && (v == '0);
    end
  end

  assign pixel_req = (region1 == REG_ACTIVE);

  // Stage 2: DAC level select; the pixel response is consumed on the edge ending the request cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      video       <= '0;
      valid       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      underruns   <= '0;
    end else begin
      valid       <= (region1 == REG_ACTIVE);
      line_start  <= line_start1;
      frame_start <= frame_start1;
      unique case (region1)
        REG_SYNC:   video <= '0;
        REG_ACTIVE: video <= pixel_valid ? pixel_level : 5'(BLACK_LEVEL);
        default:    video <= 5'(BLACK_LEVEL);
      endcase
      if (region1 == REG_ACTIVE && !pixel_valid && underruns != 8'hFF)
        underruns <= underruns + 8'd1;
    end
  end

endmodule

// File: tb/tb_video_timing_sequencer.sv
// Scoreboard bench for video_timing_sequencer using a reduced raster so full frames stay short.
// A raster-position reference model queues expected outputs; a negedge monitor compares them.
module tb_video_timing_sequencer;

  localparam int L   = 64;   // line cycles
  localparam int HS  = 5;    // hsync width
  localparam int AS  = 12;   // active start column
  localparam int AL  = 40;   // active columns
  localparam int F   = 20;   // frame lines
  localparam int VS  = 3;    // broad-pulse lines
  localparam int ALS = 5;    // first active line
  localparam int ALN = 10;   // active lines
  localparam int BL  = 9;    // black level
  localparam int FRAME = L * F;

  localparam int R_BLACK  = 0;
  localparam int R_SYNC   = 1;
  localparam int R_ACTIVE = 2;

  typedef struct packed {
    logic [4:0] video;
    logic       valid;
    logic       ls;
    logic       fs;
    logic       req;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] und;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       pixel_req;
  logic [9:0] x;
  logic [8:0] y;
  logic [4:0] pixel_level;
  logic       pixel_valid;
  logic [4:0] video;
  logic       valid;
  logic       line_start;
  logic       frame_start;
  logic [7:0] underruns;

  int   mode;
  int   drop_pct;
  bit   drop_force;
  bit   drop;
  logic [4:0] salt;

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t exp_q[$];

  video_timing_sequencer #(
    .LINE_CYCLES(L), .HSYNC_CYCLES(HS), .ACTIVE_START(AS), .ACTIVE_LEN(AL),
    .FRAME_LINES(F), .VSYNC_LINES(VS), .ACTIVE_LINE_START(ALS),
    .ACTIVE_LINES(ALN), .BLACK_LEVEL(BL)
  ) dut (
    .clk(clk), .rst(rst_n), .enable(enable),
    .pixel_req(pixel_req), .x(x), .y(y),
    .pixel_level(pixel_level), .pixel_valid(pixel_valid),
    .video(video), .valid(valid), .line_start(line_start),
    .frame_start(frame_start), .underruns(underruns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] pix(input int mode_i, input logic [9:0] px,
                                     input logic [8:0] py, input logic [4:0] s);
    if (mode_i == 0) return 5'd31;
    if (mode_i == 1) return px[4:0];
    return px[4:0] ^ py[4:0] ^ s;
  endfunction

  // Responder: combinational reply in the request cycle.
  assign pixel_level = pix(mode, x, y, salt);
  assign pixel_valid = !drop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int classify(input int hh, input int vv);
    if (vv < VS) return (hh < L - HS) ? R_SYNC : R_BLACK;
    if (hh < HS) return R_SYNC;
    if (vv >= ALS && vv < ALS + ALN && hh >= AS && hh < AS + AL) return R_ACTIVE;
    return R_BLACK;
  endfunction

  // Reference model: raster position index since (re)start, mapped to regions arithmetically.
  int         m_n;
  int         m_und;
  int         s1_reg;
  logic [9:0] s1_x;
  logic [8:0] s1_y;
  bit         s1_ls;
  bit         s1_fs;

  always @(posedge clk or negedge rst_n) begin
    obs_t e;
    int   hh;
    int   vv;
    if (!rst_n) begin
      m_n    = 0;
      m_und  = 0;
      s1_reg = R_BLACK;
      s1_x   = '0;
      s1_y   = '0;
      s1_ls  = 0;
      s1_fs  = 0;
      exp_q.delete();
    end else begin
      e.video = (s1_reg == R_SYNC) ? 5'd0 :
                (s1_reg == R_ACTIVE && !drop) ? pix(mode, s1_x, s1_y, salt) : 5'(BL);
      if (s1_reg == R_ACTIVE && drop && m_und < 255) m_und++;
      e.valid = (s1_reg == R_ACTIVE);
      e.ls    = s1_ls;
      e.fs    = s1_fs;
      if (enable) begin
        hh     = m_n % L;
        vv     = m_n / L;
        s1_reg = classify(hh, vv);
        s1_x   = (s1_reg == R_ACTIVE) ? 10'(hh - AS) : '0;
        s1_y   = (s1_reg == R_ACTIVE) ? 9'(vv - ALS) : '0;
        s1_ls  = (hh == 0);
        s1_fs  = (m_n == 0);
        m_n    = (m_n + 1) % FRAME;
      end else begin
        s1_reg = R_BLACK;
        s1_x   = '0;
        s1_y   = '0;
        s1_ls  = 0;
        s1_fs  = 0;
        m_n    = 0;
      end
      e.req = (s1_reg == R_ACTIVE);
      e.x   = s1_x;
      e.y   = s1_y;
      e.und = 8'(m_und);
      exp_q.push_back(e);
    end
  end

  // Monitor: compares every presented output cycle against the queued expectation.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{video, valid, line_start, frame_start, pixel_req, x, y, underruns};
        check("cycle{video,valid,ls,fs,req,x,y,und}", 64'(a), 64'(e));
      end
    end
  end

  // Per-cycle random response drops and data salt.
  initial begin
    drop = 0;
    salt = '0;
    forever begin
      @(negedge clk);
      drop = drop_force || ($urandom_range(0, 99) < drop_pct);
      salt = 5'($urandom);
    end
  end

  task automatic wait_for_req(input string name);
    bit seen = 0;
    for (int i = 0; i < FRAME && !seen; i++) begin
      @(negedge clk);
      if (pixel_req) seen = 1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic measure_period(input string name, input bit use_frame, input int expected);
    bit seen = 0;
    int cnt  = 0;
    for (int i = 0; i < 2 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (use_frame ? frame_start : line_start) seen = 1;
    end
    if (seen) begin
      seen = 0;
      for (int i = 0; i < 2 * FRAME && !seen; i++) begin
        @(negedge clk);
        cnt++;
        if (use_frame ? frame_start : line_start) seen = 1;
      end
    end
    check(name, 64'(cnt), 64'(expected));
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    mode       = 0;
    drop_pct   = 0;
    drop_force = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_video", 64'(video), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_req_xy", 64'({pixel_req, x, y}), 64'd0);
    check("reset_pulses", 64'({line_start, frame_start}), 64'd0);
    check("reset_underruns", 64'(underruns), 64'd0);

    // Constant responder, start from reset with timing enabled.
    rst_n  = 1'b1;
    enable = 1'b1;
    measure_period("frame_start_period", 1'b1, FRAME);
    measure_period("line_start_period", 1'b0, L);

    // Column-index responder, then random data with random drops.
    mode = 1;
    repeat (FRAME) @(negedge clk);
    mode     = 2;
    drop_pct = 20;
    repeat (FRAME) @(negedge clk);

    // Withhold every response for a whole frame (more than 255 active pixels).
    drop_force = 1;
    repeat (FRAME + 4) @(negedge clk);
    #1;
    check("underruns_saturated", 64'(underruns), 64'd255);
    drop_force = 0;
    drop_pct   = 0;
    mode       = 1;

    // Disable mid active line, then re-enable.
    wait_for_req("wait_req_before_disable");
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("disable_req_low", 64'(pixel_req), 64'd0);
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (FRAME + 10) @(negedge clk);

    // Asynchronous reset mid active line.
    wait_for_req("wait_req_before_rst");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 64'(pixel_req), 64'd0);
    check("async_rst_video_valid", 64'({video, valid}), 64'd0);
    check("async_rst_underruns", 64'(underruns), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode  = 2;
    drop_pct = 10;
    repeat (FRAME + 10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
